// File: rtl/grid_display_pkg.sv
// Shared timing constants, colour types and the tile palette for the grid VGA renderer.
package grid_display_pkg;

    localparam int H_VISIBLE     = 640;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_PULSE  = 96;
    localparam int H_BACK_PORCH  = 48;

    localparam int V_VISIBLE     = 480;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_PULSE  = 2;
    localparam int V_BACK_PORCH  = 33;

    typedef logic [23:0] rgb24;

    typedef logic [0:3][0:3][3:0] grid_t;

    typedef enum logic [2:0] {
        PIX_BLANK,
        PIX_BACKGROUND,
        PIX_BORDER,
        PIX_BAR,
        PIX_TILE
    } pix_class_t;

    localparam rgb24 BACKGROUND = 24'hFAF8EF;
    localparam rgb24 BORDER     = 24'hBBADA0;
    localparam rgb24 BAR        = 24'hFFFFFF;

    // Entry 0 is the empty-tile colour; the rest darken/warm with the exponent.
    localparam rgb24 PALETTE [16] = '{
        24'hCDC1B4, 24'hEEE4DA, 24'hEDE0C8, 24'hF2B179,
        24'hF59563, 24'hF67C5F, 24'hF65E3B, 24'hEDCF72,
        24'hEDCC61, 24'hEDC850, 24'hEDC53F, 24'hEDC22E,
        24'h3C3A32, 24'h5C5446, 24'h7C6E5A, 24'h9C886E
    };

endpackage

// File: rtl/grid_vga_renderer_if.sv
// Grid input bus plus VGA output bundle; the renderer is the master, the consumer side is the slave.
interface grid_vga_renderer_if;
    import grid_display_pkg::*;

    grid_t       grid;
    logic        vga_clk;
    logic        hsync;
    logic        vsync;
    logic        vga_blank_n;
    logic        vga_sync_n;
    logic [7:0]  red;
    logic [7:0]  green;
    logic [7:0]  blue;
    logic        frame_start;

    modport master (
        input  grid,
        output vga_clk, hsync, vsync, vga_blank_n, vga_sync_n,
        output red, green, blue, frame_start
    );

    modport slave (
        output grid,
        input  vga_clk, hsync, vsync, vga_blank_n, vga_sync_n,
        input  red, green, blue, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel-enable generator and horizontal/vertical raster counters with raw sync and active flags.
module vga_timing
    import grid_display_pkg::*;
#(
    parameter int H_ACTIVE = H_VISIBLE,
    parameter int H_FRONT  = H_FRONT_PORCH,
    parameter int H_SYNC   = H_SYNC_PULSE,
    parameter int H_BACK   = H_BACK_PORCH,
    parameter int V_ACTIVE = V_VISIBLE,
    parameter int V_FRONT  = V_FRONT_PORCH,
    parameter int V_SYNC   = V_SYNC_PULSE,
    parameter int V_BACK   = V_BACK_PORCH
) (
    input  logic       clk,
    input  logic       reset,
    output logic       o_pixEn,
    output logic       o_vgaClk,
    output logic [9:0] o_hcount,
    output logic [9:0] o_vcount,
    output logic       o_hLast,
    output logic       o_vLast,
    output logic       o_hsyncRaw,
    output logic       o_vsyncRaw,
    output logic       o_active
);

    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FRONT + V_SYNC);
    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);

    logic       r_pixEn;
    logic       r_vgaClk;
    logic [9:0] r_hcount;
    logic [9:0] r_vcount;
    logic       w_hLast;
    logic       w_vLast;

    assign w_hLast = (r_hcount == H_LAST);
    assign w_vLast = (r_vcount == V_LAST);

    // vga_clk is pix_en delayed one clk, so its rising edge coincides with each new registered pixel.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pixEn  <= 1'b0;
            r_vgaClk <= 1'b0;
            r_hcount <= '0;
            r_vcount <= '0;
        end else begin
            r_pixEn  <= ~r_pixEn;
            r_vgaClk <= r_pixEn;
            if (r_pixEn) begin
                if (w_hLast) begin
                    r_hcount <= '0;
                    r_vcount <= w_vLast ? 10'd0 : r_vcount + 10'd1;
                end else begin
                    r_hcount <= r_hcount + 10'd1;
                end
            end
        end
    end

    assign o_pixEn    = r_pixEn;
    assign o_vgaClk   = r_vgaClk;
    assign o_hcount   = r_hcount;
    assign o_vcount   = r_vcount;
    assign o_hLast    = w_hLast;
    assign o_vLast    = w_vLast;
    assign o_hsyncRaw = ~((r_hcount >= HS_START) && (r_hcount < HS_END));
    assign o_vsyncRaw = ~((r_vcount >= VS_START) && (r_vcount < VS_END));
    assign o_active   = (r_hcount < H_VIS) && (r_vcount < V_VIS);

endmodule

// File: rtl/grid_vga_renderer.sv
// Draws a per-frame snapshot of the 4x4 exponent grid as coloured tiles with width-coded bars.
module grid_vga_renderer
    import grid_display_pkg::*;
#(
    parameter int BOARD_X0  = 120,
    parameter int BOARD_Y0  = 40,
    parameter int TILE_PX   = 100,
    parameter int BORDER_PX = 4,
    parameter int BAR_UNIT  = 5,
    parameter int BAR_X0    = 8,
    parameter int BAR_Y0    = 84,
    parameter int BAR_H     = 8,
    parameter int H_ACTIVE  = H_VISIBLE,
    parameter int H_FRONT   = H_FRONT_PORCH,
    parameter int H_SYNC    = H_SYNC_PULSE,
    parameter int H_BACK    = H_BACK_PORCH,
    parameter int V_ACTIVE  = V_VISIBLE,
    parameter int V_FRONT   = V_FRONT_PORCH,
    parameter int V_SYNC    = V_SYNC_PULSE,
    parameter int V_BACK    = V_BACK_PORCH
) (
    input  logic                  clk,
    input  logic                  reset,
    grid_vga_renderer_if.master   bus
);

    localparam int LW = $clog2(TILE_PX);

    localparam logic [9:0]    X_START   = 10'(BOARD_X0);
    localparam logic [9:0]    X_END     = 10'(BOARD_X0 + 4 * TILE_PX);
    localparam logic [9:0]    Y_START   = 10'(BOARD_Y0);
    localparam logic [9:0]    Y_END     = 10'(BOARD_Y0 + 4 * TILE_PX);
    localparam logic [9:0]    SNAP_LINE = 10'(V_ACTIVE);
    localparam logic [LW-1:0] L_LAST    = LW'(TILE_PX - 1);
    localparam logic [LW-1:0] EDGE_LO   = LW'(BORDER_PX);
    localparam logic [LW-1:0] EDGE_HI   = LW'(TILE_PX - 1 - BORDER_PX);
    localparam logic [LW-1:0] BAR_TOP   = LW'(BAR_Y0);
    localparam logic [LW-1:0] BAR_BOT   = LW'(BAR_Y0 + BAR_H);
    localparam logic [9:0]    BAR_LEFT  = 10'(BAR_X0);
    localparam logic [9:0]    BAR_STEP  = 10'(BAR_UNIT);

    logic       w_pixEn;
    logic       w_vgaClk;
    logic [9:0] w_hcount;
    logic [9:0] w_vcount;
    logic       w_hLast;
    logic       w_vLast;
    logic       w_hsyncRaw;
    logic       w_vsyncRaw;
    logic       w_active;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE),
        .H_FRONT  (H_FRONT),
        .H_SYNC   (H_SYNC),
        .H_BACK   (H_BACK),
        .V_ACTIVE (V_ACTIVE),
        .V_FRONT  (V_FRONT),
        .V_SYNC   (V_SYNC),
        .V_BACK   (V_BACK)
    ) u_timing (
        .clk        (clk),
        .reset      (reset),
        .o_pixEn    (w_pixEn),
        .o_vgaClk   (w_vgaClk),
        .o_hcount   (w_hcount),
        .o_vcount   (w_vcount),
        .o_hLast    (w_hLast),
        .o_vLast    (w_vLast),
        .o_hsyncRaw (w_hsyncRaw),
        .o_vsyncRaw (w_vsyncRaw),
        .o_active   (w_active)
    );

    grid_t       r_snap;
    logic [LW-1:0] r_lx;
    logic [LW-1:0] r_ly;
    logic [1:0]  r_col;
    logic [1:0]  r_row;
    logic        r_hsync;
    logic        r_vsync;
    logic        r_blankN;
    rgb24        r_rgb;
    logic        r_frameStart;

    logic [9:0]  w_hNext;
    logic [9:0]  w_vNext;

    assign w_hNext = w_hLast ? 10'd0 : w_hcount + 10'd1;
    assign w_vNext = w_vLast ? 10'd0 : w_vcount + 10'd1;

    // Tile-local coordinates follow the raster and restart at the board's left/top edge,
    // so col/row and lx/ly are always the quotient/remainder of the board offset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_lx  <= '0;
            r_col <= '0;
            r_ly  <= '0;
            r_row <= '0;
        end else if (w_pixEn) begin
            if (w_hNext == X_START) begin
                r_lx  <= '0;
                r_col <= '0;
            end else if (r_lx == L_LAST) begin
                r_lx  <= '0;
                r_col <= r_col + 2'd1;
            end else begin
                r_lx  <= r_lx + 1'b1;
            end
            if (w_hLast) begin
                if (w_vNext == Y_START) begin
                    r_ly  <= '0;
                    r_row <= '0;
                end else if (r_ly == L_LAST) begin
                    r_ly  <= '0;
                    r_row <= r_row + 2'd1;
                end else begin
                    r_ly  <= r_ly + 1'b1;
                end
            end
        end
    end

    logic [3:0]  w_exp;
    logic        w_inBoard;
    logic        w_isBorder;
    logic        w_isBar;
    logic [9:0]  w_barEnd;
    pix_class_t  w_class;
    rgb24        w_rgb;

    assign w_exp      = r_snap[r_row][r_col];
    assign w_inBoard  = (w_hcount >= X_START) && (w_hcount < X_END) &&
                        (w_vcount >= Y_START) && (w_vcount < Y_END);
    assign w_isBorder = (r_lx < EDGE_LO) || (r_lx > EDGE_HI) ||
                        (r_ly < EDGE_LO) || (r_ly > EDGE_HI);
    assign w_barEnd   = BAR_LEFT + BAR_STEP * 10'(w_exp);
    assign w_isBar    = (w_exp != 4'd0) && (r_ly >= BAR_TOP) && (r_ly < BAR_BOT) &&
                        (10'(r_lx) >= BAR_LEFT) && (10'(r_lx) < w_barEnd);

    always_comb begin
        w_class = PIX_BLANK;
        if (!w_active) begin
            w_class = PIX_BLANK;
        end else if (!w_inBoard) begin
            w_class = PIX_BACKGROUND;
        end else if (w_isBorder) begin
            w_class = PIX_BORDER;
        end else if (w_isBar) begin
            w_class = PIX_BAR;
        end else begin
            w_class = PIX_TILE;
        end
    end

    always_comb begin
        w_rgb = '0;
        case (w_class)
            PIX_BACKGROUND: w_rgb = BACKGROUND;
            PIX_BORDER:     w_rgb = BORDER;
            PIX_BAR:        w_rgb = BAR;
            PIX_TILE:       w_rgb = PALETTE[w_exp];
            default:        w_rgb = '0;
        endcase
    end

    // Sync, blank and colour share one register stage; the snapshot is taken at the
    // first pixel of vertical blanking so a frame never mixes two grid states.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_hsync      <= 1'b1;
            r_vsync      <= 1'b1;
            r_blankN     <= 1'b0;
            r_rgb        <= '0;
            r_frameStart <= 1'b0;
            r_snap       <= '0;
        end else begin
            r_frameStart <= 1'b0;
            if (w_pixEn) begin
                r_hsync  <= w_hsyncRaw;
                r_vsync  <= w_vsyncRaw;
                r_blankN <= w_active;
                r_rgb    <= w_rgb;
                if ((w_hcount == 10'd0) && (w_vcount == SNAP_LINE)) begin
                    r_snap       <= bus.grid;
                    r_frameStart <= 1'b1;
                end
            end
        end
    end

    assign bus.vga_clk     = w_vgaClk;
    assign bus.hsync       = r_hsync;
    assign bus.vsync       = r_vsync;
    assign bus.vga_blank_n = r_blankN;
    assign bus.vga_sync_n  = 1'b0;
    assign bus.red         = r_rgb[23:16];
    assign bus.green       = r_rgb[15:8];
    assign bus.blue        = r_rgb[7:0];
    assign bus.frame_start = r_frameStart;

endmodule

// File: tb/tb_grid_vga_renderer.sv
// Scoreboard bench: random grid updates feed a pixel-level reference model on a scaled-down raster.
module tb_grid_vga_renderer;

    localparam int HA = 88, HF = 4, HS = 4, HB = 4, HT = HA + HF + HS + HB;
    localparam int VA = 86, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
    localparam int BX = 4, BY = 3, TP = 20, BP = 2, BU = 1;
    localparam int BAX = 3, BAY = 14, BAH = 3;

    localparam logic [23:0] C_BG     = 24'hFAF8EF;
    localparam logic [23:0] C_BORDER = 24'hBBADA0;
    localparam logic [23:0] C_BAR    = 24'hFFFFFF;
    localparam logic [23:0] PAL [16] = '{
        24'hCDC1B4, 24'hEEE4DA, 24'hEDE0C8, 24'hF2B179,
        24'hF59563, 24'hF67C5F, 24'hF65E3B, 24'hEDCF72,
        24'hEDCC61, 24'hEDC850, 24'hEDC53F, 24'hEDC22E,
        24'h3C3A32, 24'h5C5446, 24'h7C6E5A, 24'h9C886E
    };

    typedef struct packed {
        logic [9:0]  x;
        logic [9:0]  y;
        logic        hs;
        logic        vs;
        logic        bl;
        logic        fs;
        logic        sn;
        logic [23:0] rgb;
    } pix_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    bit   monitorOn = 1'b0;
    int   phase = 0;
    int   vectors = 0;
    int   miscompares = 0;
    int   tbGrid [4][4];
    int   snapM [4][4];
    pix_t expQ [$];

    grid_vga_renderer_if bus();

    grid_vga_renderer #(
        .BOARD_X0 (BX), .BOARD_Y0 (BY), .TILE_PX (TP), .BORDER_PX (BP), .BAR_UNIT (BU),
        .BAR_X0 (BAX), .BAR_Y0 (BAY), .BAR_H (BAH),
        .H_ACTIVE (HA), .H_FRONT (HF), .H_SYNC (HS), .H_BACK (HB),
        .V_ACTIVE (VA), .V_FRONT (VF), .V_SYNC (VS), .V_BACK (VB)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #10 clk = ~clk;

    task automatic fail(input string name, input string detail);
        miscompares++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    // Reference colour from plain division/modulo of the board offset.
    function automatic logic [23:0] expectRgb(input int x, input int y);
        int col, row, lx, ly, e;
        if (x >= HA || y >= VA) return 24'h000000;
        if (x < BX || x >= BX + 4 * TP || y < BY || y >= BY + 4 * TP) return C_BG;
        col = (x - BX) / TP;
        row = (y - BY) / TP;
        lx  = (x - BX) % TP;
        ly  = (y - BY) % TP;
        e   = snapM[row][col];
        if (lx < BP || lx > TP - 1 - BP || ly < BP || ly > TP - 1 - BP) return C_BORDER;
        if (e != 0 && ly >= BAY && ly < BAY + BAH && lx >= BAX && lx <= BAX - 1 + BU * e) return C_BAR;
        return PAL[e];
    endfunction

    task automatic applyStimulus(input int k);
        int x, y, r, c;
        pix_t want;
        x = k % HT;
        y = (k / HT) % VT;
        if ((y == VA && x <= 1) || (y == VA - 1 && x == HT - 1) || $urandom_range(0, 299) == 0) begin
            r = int'($urandom_range(0, 3));
            c = int'($urandom_range(0, 3));
            tbGrid[r][c] = int'($urandom_range(0, 15));
            bus.grid[r][c] = 4'(tbGrid[r][c]);
        end
        if (x == 0 && y == VA) begin
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++)
                    snapM[i][j] = tbGrid[i][j];
        end
        want.x   = 10'(x);
        want.y   = 10'(y);
        want.hs  = !(x >= HA + HF && x < HA + HF + HS);
        want.vs  = !(y >= VA + VF && y < VA + VF + VS);
        want.bl  = (x < HA && y < VA);
        want.fs  = (x == 0 && y == VA);
        want.sn  = 1'b0;
        want.rgb = expectRgb(x, y);
        expQ.push_back(want);
    endtask

    task automatic checkOutput();
        pix_t want, got;
        logic expClk;
        expClk = (phase % 2 == 0);
        vectors++;
        if (bus.vga_clk !== expClk)
            fail("vga_clk", $sformatf("phase %0d got %b want %b", phase, bus.vga_clk, expClk));
        if (bus.vga_clk === 1'b1) begin
            vectors++;
            if (expQ.size() == 0) begin
                fail("unexpected_pixel", "got a pixel want none queued");
            end else begin
                want = expQ.pop_front();
                got.x   = want.x;
                got.y   = want.y;
                got.hs  = bus.hsync;
                got.vs  = bus.vsync;
                got.bl  = bus.vga_blank_n;
                got.fs  = bus.frame_start;
                got.sn  = bus.vga_sync_n;
                got.rgb = {bus.red, bus.green, bus.blue};
                if (got !== want)
                    fail("pixel", $sformatf("(%0d,%0d) got hs=%b vs=%b bl=%b fs=%b sn=%b rgb=%06h want hs=%b vs=%b bl=%b fs=%b sn=%b rgb=%06h",
                         want.x, want.y, got.hs, got.vs, got.bl, got.fs, got.sn, got.rgb,
                         want.hs, want.vs, want.bl, want.fs, want.sn, want.rgb));
            end
        end else begin
            vectors++;
            if (bus.frame_start !== 1'b0)
                fail("frame_start_width", $sformatf("phase %0d got %b want 0", phase, bus.frame_start));
        end
    endtask

    task automatic checkResetState(input string name);
        logic [28:0] got, want;
        got  = {bus.hsync, bus.vsync, bus.vga_blank_n, bus.frame_start, bus.vga_clk,
                bus.red, bus.green, bus.blue};
        want = {1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
        vectors++;
        if (got !== want)
            fail(name, $sformatf("got hs,vs,bl,fs,vclk,rgb=%08h want %08h", got, want));
    endtask

    task automatic runPixels(input int n);
        for (int k = 0; k < n; k++) begin
            applyStimulus(k);
            repeat (2) @(negedge clk);
        end
    endtask

    task automatic drainCheck(input string name);
        vectors++;
        if (expQ.size() != 0)
            fail(name, $sformatf("got %0d pixels pending want 0", expQ.size()));
        expQ.delete();
    endtask

    always @(negedge clk) begin
        #2;
        if (monitorOn) begin
            checkOutput();
            phase++;
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got no completion within time limit, want completion");
        $fatal(1, "[TB] time limit reached");
    end

    initial begin
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                tbGrid[i][j] = int'($urandom_range(1, 15));
                bus.grid[i][j] = 4'(tbGrid[i][j]);
                snapM[i][j] = 0;
            end
        end
        $display("[TB] reset held for 3 clocks");
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #2 checkResetState("reset_state");
        reset = 1'b0;
        @(negedge clk);
        phase = 1;
        monitorOn = 1'b1;
        $display("[TB] running two frames plus 40 lines with random grid updates");
        runPixels(2 * HT * VT + 40 * HT + 37);
        drainCheck("drain_run1");

        $display("[TB] asserting reset mid-frame");
        monitorOn = 1'b0;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #2 checkResetState("midframe_reset_state");
        for (int i = 0; i < 4; i++)
            for (int j = 0; j < 4; j++)
                snapM[i][j] = 0;
        reset = 1'b0;
        @(negedge clk);
        phase = 1;
        monitorOn = 1'b1;
        runPixels(60 * HT);
        drainCheck("drain_run2");
        monitorOn = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
